mem_preloader: RTL and testbench
================================

// Module: mem_preloader
// PURPOSE
//  Hardware program/data loader. Streams words from a valid/ready source into NUM_BANKS
//  single-port SRAM banks (bank0 = DM, bank1 = IM by default) through their active-low
//  cen/wen/oen load ports, and holds the processor in load mode while doing so.
//  Replaces the bench-driven dm_write/im_write loop, generalising word width, bank depth,
//  bank count and fill order.
// PARAMETERS
//  DATA_W     32    word width
//  ADDR_W     11    bank address width
//  DEPTH      2048  words per bank to load (<= 2**ADDR_W)
//  NUM_BANKS  2     number of target banks (>= 1)
//  INTERLEAVE 1     1: b0[0],b1[0],..,b0[1].. ; 0: all of b0, then all of b1, ...
// PORTS
//  clk           in   1                   clock
//  rst_n         in   1                   async active-low reset
//  start         in   1                   pulse; begins a load when idle
//  abort         in   1                   pulse; cancels load, back to idle
//  in_valid      in   1                   source word valid
//  in_data       in   DATA_W              source word
//  in_ready      out  1                   loader accepts in_data this cycle
//  loading       out  1                   high from start-accept until done/abort
//  bank_cen      out  NUM_BANKS           per-bank chip enable, active low
//  bank_wen      out  NUM_BANKS           per-bank write enable, active low
//  bank_oen      out  NUM_BANKS           per-bank output enable, active low
//  bank_addr     out  ADDR_W              shared address
//  bank_datain   out  DATA_W              shared write data
//  bank_dataout  in   NUM_BANKS*DATA_W    read data, bank i at [i*DATA_W +: DATA_W]
//  word_count    out  $clog2(NUM_BANKS*DEPTH)+1   words written this load
//  done          out  1                   one-cycle pulse at normal completion
//  err           out  1                   sticky readback mismatch (verify build only)
// BEHAVIOUR
//  Reset (async): state IDLE; bank_cen/wen/oen all 1; bank_addr, bank_datain, word_count 0;
//   in_ready, loading, done, err 0.
//  FSM: IDLE -start-> LOAD; LOAD -last word written-> FINISH; FINISH -> IDLE (done=1 for
//   this one cycle, loading=0). abort in any non-IDLE state -> IDLE next cycle, no done.
//  start ignored outside IDLE; abort has priority over start and in_valid in the same cycle.
//  LOAD: in_ready=1 (no verify build). Transfer on in_valid&&in_ready. Write is registered:
//   next cycle the selected bank sees cen=0, wen=0, oen=1 with addr/datain; all other banks
//   cen=1. Strobe lasts exactly one cycle. Cycles without a transfer drive all cen/wen=1.
//  Latency: transfer -> write strobe 1 cycle; throughput 1 word/cycle.
//  Index k = word_count before increment. INTERLEAVE=1: bank=k%NUM_BANKS, addr=k/NUM_BANKS.
//   INTERLEAVE=0: bank=k/DEPTH, addr=k%DEPTH. Counters are wrap-free: after word
//   NUM_BANKS*DEPTH-1, in_ready drops the same cycle and FSM enters FINISH after the strobe.
//  word_count holds its final value until next start (cleared on start accept).
//  Reset mid-load: immediate return to reset values; partially written banks are left as is.
// CONFIGURATION
//  MEM_PRELOADER_VERIFY_EN defined: after each write strobe, one read cycle (cen=0, wen=1,
//   oen=0, same addr), then one compare cycle against the saved word; mismatch sets err
//   (sticky, cleared on start accept). in_ready=0 during read/compare -> 1 word / 3 cycles.
//   Final word's compare completes before FINISH.
//  Not defined: no read cycles, err tied 0, bank_dataout unused, 1 word/cycle.
// STRUCTURE
//  mem_preloader_pkg: state encoding (IDLE, LOAD, RDBK, CMP, FINISH), strobe constants
//   (STB_ON=1'b0, STB_OFF=1'b1), count-width function.
//  Sub-module mem_preloader_addr_gen: k, INTERLEAVE -> (bank index, addr, last); combinational
//   over the registered counter.
// TESTING  (DEPTH=4, NUM_BANKS=2 unless stated)
//  1 INTERLEAVE=1, in_valid held, data 0xA0..0xA7 -> b0[0..3]=A0,A2,A4,A6; b1[0..3]=A1,A3,A5,A7;
//    8 consecutive strobes; done pulses 1 cycle after last strobe; word_count=8; loading=0.
//  2 INTERLEAVE=0, same data -> b0[0..3]=A0..A3, b1[0..3]=A4..A7.
//  3 in_valid alternating 1/0 -> strobes only after valid cycles, contents as test 1, done
//    after 8th word.
//  4 rst_n low after 3rd transfer -> all outputs reset values immediately; new start
//    rewrites from b0[0] with word_count restarting at 0.
//  5 start during LOAD ignored (word_count continues); abort after 5 words -> IDLE, no done,
//    loading=0, word_count=5.
//  6 VERIFY_EN, bank model corrupts b1[2] -> err=1 after compare of word index 5, stays 1
//    through done; in_ready duty 1/3; without macro err stays 0.

Source files
------------

// File: rtl/mem_preloader_pkg.sv
// mem_preloader_pkg: shared state encoding, active-low strobe levels and width helpers
package mem_preloader_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RDBK, S_CMP, S_FINISH} state_t;
  localparam logic STB_ON  = 1'b0;
  localparam logic STB_OFF = 1'b1;
  function automatic int cnt_w(input int banks, input int depth);
    return $clog2(banks * depth) + 1;
  endfunction
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mem_preloader_addr_gen.sv
// mem_preloader_addr_gen: maps the running word index onto (bank, address, last-word flag)
module mem_preloader_addr_gen import mem_preloader_pkg::*; #(
  parameter int ADDR_W     = 11,
  parameter int DEPTH      = 2048,
  parameter int NUM_BANKS  = 2,
  parameter int INTERLEAVE = 1,
  localparam int CW = cnt_w(NUM_BANKS, DEPTH),
  localparam int BW = idx_w(NUM_BANKS)
) (
  input  logic [CW-1:0]     i_k,
  output logic [BW-1:0]     o_bank,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);
  always_comb begin
    o_bank = BW'(INTERLEAVE != 0 ? int'(i_k) % NUM_BANKS : int'(i_k) / DEPTH);
    o_addr = ADDR_W'(INTERLEAVE != 0 ? int'(i_k) / NUM_BANKS : int'(i_k) % DEPTH);
    o_last = int'(i_k) == NUM_BANKS * DEPTH - 1;
  end
endmodule

// File: rtl/mem_preloader.sv
// mem_preloader: streams source words into NUM_BANKS SRAM banks through their active-low load ports.
// Define MEM_PRELOADER_VERIFY_EN to read back and compare every word (bank read data sampled in the compare cycle).
module mem_preloader import mem_preloader_pkg::*; #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 11,
  parameter int DEPTH      = 2048,
  parameter int NUM_BANKS  = 2,
  parameter int INTERLEAVE = 1,
  localparam int CW = cnt_w(NUM_BANKS, DEPTH),
  localparam int BW = idx_w(NUM_BANKS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_start,
  input  logic                        i_abort,
  input  logic                        i_in_valid,
  input  logic [DATA_W-1:0]           i_in_data,
  output logic                        o_in_ready,
  output logic                        o_loading,
  output logic [NUM_BANKS-1:0]        o_bank_cen,
  output logic [NUM_BANKS-1:0]        o_bank_wen,
  output logic [NUM_BANKS-1:0]        o_bank_oen,
  output logic [ADDR_W-1:0]           o_bank_addr,
  output logic [DATA_W-1:0]           o_bank_datain,
  input  logic [NUM_BANKS*DATA_W-1:0] i_bank_dataout,
  output logic [CW-1:0]               o_word_count,
  output logic                        o_done,
  output logic                        o_err
);
  state_t               r_state, w_next;
  logic                 r_last, w_last, w_start, w_xfer, w_rd_stb;
  logic [CW-1:0]        r_count;
  logic [BW-1:0]        r_bank, w_bank;
  logic [ADDR_W-1:0]    r_addr, w_addr;
  logic [DATA_W-1:0]    r_data;
  logic [NUM_BANKS-1:0] r_cen, r_wen, r_oen, w_wr_sel, w_rd_sel;

  mem_preloader_addr_gen #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .NUM_BANKS(NUM_BANKS), .INTERLEAVE(INTERLEAVE)
  ) u_addr_gen (
    .i_k(r_count), .o_bank(w_bank), .o_addr(w_addr), .o_last(w_last)
  );

`ifdef MEM_PRELOADER_VERIFY_EN
  localparam bit VERIFY = 1'b1;
  logic r_err;
  assign w_rd_stb = r_state == S_RDBK && !i_abort;
  assign o_err    = r_err;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_err <= 1'b0;
    else if (w_start) r_err <= 1'b0;
    else if (r_state == S_CMP && i_bank_dataout[r_bank*DATA_W +: DATA_W] != r_data) r_err <= 1'b1;
`else
  localparam bit VERIFY = 1'b0;
  logic w_unused;
  assign w_unused = ^i_bank_dataout;
  assign w_rd_stb = 1'b0;
  assign o_err    = 1'b0;
`endif

  always_comb begin
    w_start    = r_state == S_IDLE && i_start && !i_abort;
    o_in_ready = r_state == S_LOAD && !r_last && !i_abort;
    w_xfer     = o_in_ready && i_in_valid;
    o_loading  = r_state inside {S_LOAD, S_RDBK, S_CMP};
    o_done     = r_state == S_FINISH && !i_abort;
    w_next = i_abort              ? S_IDLE :
             r_state == S_IDLE    ? (i_start ? S_LOAD : S_IDLE) :
             r_state == S_LOAD    ? (r_last ? S_FINISH : (VERIFY && w_xfer) ? S_RDBK : S_LOAD) :
             r_state == S_RDBK    ? S_CMP :
             r_state == S_CMP     ? (r_last ? S_FINISH : S_LOAD) : S_IDLE;
    for (int i = 0; i < NUM_BANKS; i++) begin
      w_wr_sel[i] = w_bank == BW'(i) ? STB_ON : STB_OFF;
      w_rd_sel[i] = r_bank == BW'(i) ? STB_ON : STB_OFF;
    end
  end

  // strobes are rebuilt every cycle so each one lasts exactly one clock
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_last  <= 1'b0;
      r_count <= '0;
      r_bank  <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_cen   <= {NUM_BANKS{STB_OFF}};
      r_wen   <= {NUM_BANKS{STB_OFF}};
      r_oen   <= {NUM_BANKS{STB_OFF}};
    end else begin
      r_state <= w_next;
      r_cen   <= w_xfer ? w_wr_sel : w_rd_stb ? w_rd_sel : {NUM_BANKS{STB_OFF}};
      r_wen   <= w_xfer ? w_wr_sel : {NUM_BANKS{STB_OFF}};
      r_oen   <= w_rd_stb ? w_rd_sel : {NUM_BANKS{STB_OFF}};
      if (w_start) begin
        r_count <= '0;
        r_last  <= 1'b0;
      end else if (w_xfer) begin
        r_count <= r_count + CW'(1);
        r_last  <= w_last;
        r_bank  <= w_bank;
        r_addr  <= w_addr;
        r_data  <= i_in_data;
      end
    end

  assign o_bank_cen    = r_cen;
  assign o_bank_wen    = r_wen;
  assign o_bank_oen    = r_oen;
  assign o_bank_addr   = r_addr;
  assign o_bank_datain = r_data;
  assign o_word_count  = r_count;
endmodule

// File: tb/tb_mem_preloader.sv
// tb_mem_preloader: directed load sequences into two loaders (INTERLEAVE 0 and 1) with flow-through bank models.
module tb_mem_preloader;
  localparam int DW = 32, AW = 2, DP = 4, NB = 2, CW = 4;
`ifdef MEM_PRELOADER_VERIFY_EN
  localparam bit VER = 1'b1;
`else
  localparam bit VER = 1'b0;
`endif
  logic clk = 0, rst_n = 0, start = 0, abort = 0, in_valid = 0;
  logic [DW-1:0] in_data = 0;
  logic rdy[2], ld[2], done[2], err[2];
  logic [NB-1:0] cen[2], wen[2], oen[2];
  logic [AW-1:0] addr[2];
  logic [DW-1:0] din[2];
  logic [NB*DW-1:0] dout[2];
  logic [CW-1:0] wc[2];
  logic [DW-1:0] mem[2][NB][DP];
  bit wipe = 0, corrupt = 0, done_ld, done_er;
  int n_vec = 0, n_err = 0, cyc = 0, n_stb = 0, n_done = 0;
  int first_stb, last_stb, s6, done_cyc, err_cyc = -1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_preloader #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP), .NUM_BANKS(NB), .INTERLEAVE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_abort(abort), .i_in_valid(in_valid),
    .i_in_data(in_data), .o_in_ready(rdy[0]), .o_loading(ld[0]), .o_bank_cen(cen[0]),
    .o_bank_wen(wen[0]), .o_bank_oen(oen[0]), .o_bank_addr(addr[0]), .o_bank_datain(din[0]),
    .i_bank_dataout(dout[0]), .o_word_count(wc[0]), .o_done(done[0]), .o_err(err[0]));

  mem_preloader #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP), .NUM_BANKS(NB), .INTERLEAVE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_abort(abort), .i_in_valid(in_valid),
    .i_in_data(in_data), .o_in_ready(rdy[1]), .o_loading(ld[1]), .o_bank_cen(cen[1]),
    .o_bank_wen(wen[1]), .o_bank_oen(oen[1]), .o_bank_addr(addr[1]), .o_bank_datain(din[1]),
    .i_bank_dataout(dout[1]), .o_word_count(wc[1]), .o_done(done[1]), .o_err(err[1]));

  // bank model; corrupt flips bit 0 of anything written to bank1 address 2
  always @(posedge clk)
    for (int d = 0; d < 2; d++)
      for (int b = 0; b < NB; b++)
        if (wipe) for (int a = 0; a < DP; a++) mem[d][b][a] <= '0;
        else if (!cen[d][b] && !wen[d][b]) mem[d][b][addr[d]] <= din[d] ^ DW'(corrupt && b == 1 && addr[d] == 2);

  always_comb
    for (int d = 0; d < 2; d++) dout[d] = {mem[d][1][addr[d]], mem[d][0][addr[d]]};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (|(~cen[1] & ~wen[1])) begin
      chk("onehot_stb", 64'($countones(~cen[1])), 1);
      if (n_stb == 0) first_stb = cyc;
      last_stb = cyc;
      n_stb++;
      if (n_stb == 6) s6 = cyc;
    end
    if (done[1]) begin
      n_done++;
      done_cyc = cyc;
      done_ld = ld[1];
      done_er = err[1];
    end
    if (err[1] && err_cyc < 0) err_cyc = cyc;
  end

  task automatic chk_rst();
    chk("rst_cen", cen[1], 2'b11);
    chk("rst_wen", wen[1], 2'b11);
    chk("rst_oen", oen[1], 2'b11);
    chk("rst_addr", addr[1], 0);
    chk("rst_din", din[1], 0);
    chk("rst_wc", wc[1], 0);
    chk("rst_rdy", rdy[1], 0);
    chk("rst_ld", ld[1], 0);
    chk("rst_done", done[1], 0);
    chk("rst_err", err[1], 0);
  endtask

  task automatic do_wipe();
    @(negedge clk) wipe = 1;
    @(negedge clk) wipe = 0;
  endtask

  task automatic go();
    n_stb = 0;
    n_done = 0;
    err_cyc = -1;
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    #2;
    chk("start_ld", ld[1], 1);
    chk("start_wc", wc[1], 0);
  endtask

  task automatic feed(input int n, input bit alt, input int st_at);
    int idx = 0;
    bit x;
    for (int t = 0; t < 200 && idx < n; t++) begin
      @(negedge clk);
      in_valid = !alt || t % 2 == 0;
      in_data = 32'hA0 + 32'(idx);
      start = idx == st_at;
      #1 x = rdy[1] && in_valid;
      @(posedge clk);
      if (x) idx++;
    end
    @(negedge clk);
    in_valid = 0;
    start = 0;
    chk("feed_cnt", idx, n);
  endtask

  task automatic wait_done();
    for (int w = 0; w < 20 && n_done == 0; w++) begin
      @(negedge clk);
      #2;
    end
    chk("done_seen", n_done, 1);
    repeat (3) @(negedge clk);
    #2;
    chk("done_1cyc", n_done, 1);
    chk("done_ld", done_ld, 0);
    chk("end_ld", ld[1], 0);
    chk("end_wc1", wc[1], 8);
    chk("end_wc0", wc[0], 8);
  endtask

  task automatic fin(input bit alt);
    wait_done();
    chk("n_stb", n_stb, 8);
    chk("done_lat", done_cyc - last_stb, VER ? 2 : 1);
    chk("stb_span", last_stb - first_stb, VER ? (alt ? 28 : 21) : (alt ? 14 : 7));
    for (int d = 0; d < 2; d++)
      for (int b = 0; b < NB; b++)
        for (int a = 0; a < DP; a++)
          chk($sformatf("mem%0d_b%0d_a%0d", d, b, a), mem[d][b][a], 32'hA0 + 32'(d ? a * NB + b : b * DP + a));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk_rst();
    rst_n = 1;
    do_wipe();
    go();
    feed(8, 0, -1);
    fin(0);
    do_wipe();
    go();
    feed(8, 1, -1);
    fin(1);
    do_wipe();
    go();
    feed(3, 0, -1);
    rst_n = 0;
    #1;
    chk_rst();
    @(negedge clk);
    #2;
    chk("part_b0a0", mem[1][0][0], 32'hA0);
    chk("part_b1a0", mem[1][1][0], 32'hA1);
    chk("part_b0a1", mem[1][0][1], 0);
    rst_n = 1;
    do_wipe();
    go();
    feed(8, 0, -1);
    fin(0);
    go();
    feed(5, 0, 2);
    abort = 1;
    in_valid = 1;
    #1 chk("abort_rdy", rdy[1], 0);
    @(negedge clk);
    abort = 0;
    in_valid = 0;
    #2;
    chk("abort_ld", ld[1], 0);
    chk("abort_wc", wc[1], 5);
    chk("abort_rdy2", rdy[1], 0);
    repeat (4) @(negedge clk);
    chk("abort_nodone", n_done, 0);
    do_wipe();
    corrupt = 1;
    go();
    feed(8, 0, -1);
    wait_done();
    chk("err_at_done", done_er, VER);
    chk("err_cyc", err_cyc, VER ? s6 + 2 : -1);
    chk("err_hold1", err[1], VER);
    chk("err_hold0", err[0], VER);
    corrupt = 0;
    go();
    chk("err_clr", err[1], 0);
    @(negedge clk) abort = 1;
    @(negedge clk) abort = 0;
    #2 chk("final_ld", ld[1], 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
